// File: rtl/hex_extrema_tracker.sv
// rtl/hex_extrema_tracker.sv - frame-based running max/min tracker driving an external cascaded comparator
//
// Purpose:
//   Accepts a stream of unsigned W-bit samples grouped into frames and tracks
//   the running maximum and minimum with their 0-based positions. The actual
//   magnitude compare is done by an external combinational comparator
//   (hex_comparator). The comparator is shared between two passes per sample:
//   first the sample against the stored max, then against the stored min.
//   When the frame's last sample has been processed, the results are held on
//   the output until downstream takes them.
//
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   - sample handshake; in_data is the sample, in_last
//                         marks the final sample of a frame
//   cmp_a, cmp_b        - comparator operands (zero when comparator idle)
//   cmp_e, cmp_l, cmp_g - comparator cascade inputs, tied to "equal so far"
//   cmp_E, cmp_L, cmp_G - comparator results a==b, a<b, a>b
//   out_valid/out_ready - frame result handshake
//   max_val, min_val    - frame extrema
//   max_idx, min_idx    - frame positions of the extrema
//   count               - samples seen in the frame (saturating)
//   cmp_err             - sticky: comparator returned a non-one-hot result

module hex_extrema_tracker #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic [W-1:0]     cmp_a,
  output logic [W-1:0]     cmp_b,
  output logic             cmp_e,
  output logic             cmp_l,
  output logic             cmp_g,
  input  logic             cmp_E,
  input  logic             cmp_L,
  input  logic             cmp_G,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     max_val,
  output logic [W-1:0]     min_val,
  output logic [CNT_W-1:0] max_idx,
  output logic [CNT_W-1:0] min_idx,
  output logic [CNT_W-1:0] count,
  output logic             cmp_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMP_MAX = 2'd1,
    CMP_MIN = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [W-1:0]     r_max_val;
  logic [W-1:0]     r_min_val;
  logic [CNT_W-1:0] r_max_idx;
  logic [CNT_W-1:0] r_min_idx;
  logic [CNT_W-1:0] r_count;
  logic [W-1:0]     r_s;
  logic             r_l;
  logic [CNT_W-1:0] r_s_idx;
  logic             r_err;
  logic             r_out_valid;

  logic             w_in_ready;
  logic [W-1:0]     w_cmp_a;
  logic [W-1:0]     w_cmp_b;
  logic             w_accept;
  logic             w_first;
  logic             w_cmp_legal;
  logic [CNT_W-1:0] w_count_inc;

  assign w_accept = in_valid && w_in_ready;
  assign w_first  = (r_count == '0);

  // A well-formed comparator result has exactly one of E/L/G asserted.
  assign w_cmp_legal = ({cmp_E, cmp_L, cmp_G} == 3'b100) ||
                       ({cmp_E, cmp_L, cmp_G} == 3'b010) ||
                       ({cmp_E, cmp_L, cmp_G} == 3'b001);

  // Count saturates at all-ones; later samples keep reporting that index.
  assign w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_cmp_a      = '0;
    w_cmp_b      = '0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          if (w_first) begin
            w_next_state = in_last ? DONE : IDLE;
          end else begin
            w_next_state = CMP_MAX;
          end
        end
      end
      CMP_MAX: begin
        w_cmp_a      = r_s;
        w_cmp_b      = r_max_val;
        w_next_state = CMP_MIN;
      end
      CMP_MIN: begin
        w_cmp_a      = r_s;
        w_cmp_b      = r_min_val;
        w_next_state = r_l ? DONE : IDLE;
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max_val   <= '0;
      r_min_val   <= '0;
      r_max_idx   <= '0;
      r_min_idx   <= '0;
      r_count     <= '0;
      r_s         <= '0;
      r_l         <= 1'b0;
      r_s_idx     <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // Result valid is simply "we will be in DONE next cycle".
      r_out_valid <= (w_next_state == DONE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_first) begin
              // First sample seeds both extrema; no compare needed.
              r_max_val <= in_data;
              r_min_val <= in_data;
              r_max_idx <= '0;
              r_min_idx <= '0;
              r_count   <= CNT_W'(1);
            end else begin
              r_s     <= in_data;
              r_l     <= in_last;
              r_s_idx <= r_count;
              r_count <= w_count_inc;
            end
          end
        end
        CMP_MAX: begin
          if (!w_cmp_legal) begin
            r_err <= 1'b1;
          end else if (cmp_G) begin
            r_max_val <= r_s;
            r_max_idx <= r_s_idx;
          end
        end
        CMP_MIN: begin
          if (!w_cmp_legal) begin
            r_err <= 1'b1;
          end else if (cmp_L) begin
            r_min_val <= r_s;
            r_min_idx <= r_s_idx;
          end
        end
        DONE: begin
          // Extrema are left in place; the next first sample overwrites them.
          if (out_ready) begin
            r_count <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign cmp_a     = w_cmp_a;
  assign cmp_b     = w_cmp_b;
  assign cmp_e     = 1'b1;
  assign cmp_l     = 1'b0;
  assign cmp_g     = 1'b0;
  assign out_valid = r_out_valid;
  assign max_val   = r_max_val;
  assign min_val   = r_min_val;
  assign max_idx   = r_max_idx;
  assign min_idx   = r_min_idx;
  assign count     = r_count;
  assign cmp_err   = r_err;

endmodule

// File: tb/tb_hex_extrema_tracker.sv
// tb/tb_hex_extrema_tracker.sv - directed self-checking bench for hex_extrema_tracker

module tb_hex_extrema_tracker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [15:0] cmp_a;
  logic [15:0] cmp_b;
  logic        cmp_e;
  logic        cmp_l;
  logic        cmp_g;
  logic        cmp_E;
  logic        cmp_L;
  logic        cmp_G;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] max_val;
  logic [15:0] min_val;
  logic [7:0]  max_idx;
  logic [7:0]  min_idx;
  logic [7:0]  count;
  logic        cmp_err;

  logic        force_bad;
  int          errors;
  int          checks;

  hex_extrema_tracker #(.W(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_e     (cmp_e),
    .cmp_l     (cmp_l),
    .cmp_g     (cmp_g),
    .cmp_E     (cmp_E),
    .cmp_L     (cmp_L),
    .cmp_G     (cmp_G),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max_val   (max_val),
    .min_val   (min_val),
    .max_idx   (max_idx),
    .min_idx   (min_idx),
    .count     (count),
    .cmp_err   (cmp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural external comparator, with an override producing E=G=1.
  always_comb begin
    if (force_bad) begin
      cmp_E = 1'b1;
      cmp_L = 1'b0;
      cmp_G = 1'b1;
    end else begin
      cmp_E = (cmp_a == cmp_b);
      cmp_L = (cmp_a <  cmp_b);
      cmp_G = (cmp_a >  cmp_b);
    end
  end

  // Entered and left at a negedge; returns just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1 within 20 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_timeout: out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out_valid=%0b count=%0d in_ready=%0b required 0 0 1", out_valid, count, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(16'h1111, 1'b0);
    send(16'h8000, 1'b0);
    checks++;
    if (cmp_a !== 16'h8000 || cmp_b !== 16'h1111) begin
      errors++;
      $display("FAIL cmp_max_operands: a=%h b=%h required 8000 1111", cmp_a, cmp_b);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 8'd0 || max_val !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_cmp: out_valid=%0b count=%0d max=%h required 0 0 0000", out_valid, count, max_val);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || cmp_a !== 16'h0 || cmp_b !== 16'h0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b a=%h b=%h required 1 0 0", in_ready, cmp_a, cmp_b);
    end
  endtask

  task automatic test_frame_basic();
    send(16'h0000, 1'b0);
    send(16'h8000, 1'b0);
    send(16'hFFFE, 1'b0);
    send(16'hFFFF, 1'b1);
    wait_out();
    checks++;
    if (max_val !== 16'hFFFF || max_idx !== 8'd3 || min_val !== 16'h0000 ||
        min_idx !== 8'd0 || count !== 8'd4 || cmp_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_basic: max=%h@%0d min=%h@%0d cnt=%0d err=%0b required ffff@3 0000@0 4 0",
               max_val, max_idx, min_val, min_idx, count, cmp_err);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || count !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_consume: out_valid=%0b count=%0d in_ready=%0b required 0 0 1", out_valid, count, in_ready);
    end
  endtask

  task automatic test_ties();
    logic [2:0] rdy;
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b0);
    rdy[0] = in_ready;
    @(negedge clk);
    rdy[1] = in_ready;
    @(negedge clk);
    rdy[2] = in_ready;
    checks++;
    if (rdy !== 3'b100) begin
      errors++;
      $display("FAIL ready_gap_mid: in_ready seq=%b required 100", rdy);
    end
    send(16'hFFFE, 1'b1);
    rdy[0] = in_ready;
    @(negedge clk);
    rdy[1] = in_ready;
    @(negedge clk);
    rdy[2] = out_valid;
    checks++;
    if (rdy !== 3'b100) begin
      errors++;
      $display("FAIL ready_gap_last: in_ready,in_ready,out_valid=%b required 100", rdy);
    end
    checks++;
    if (max_val !== 16'hFFFF || max_idx !== 8'd0 || min_val !== 16'hFFFE ||
        min_idx !== 8'd2 || count !== 8'd3) begin
      errors++;
      $display("FAIL ties: max=%h@%0d min=%h@%0d cnt=%0d required ffff@0 fffe@2 3",
               max_val, max_idx, min_val, min_idx, count);
    end
    consume();
  endtask

  task automatic test_single();
    int bad;
    send(16'h1234, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || max_val !== 16'h1234 || min_val !== 16'h1234 || count !== 8'd1 ||
        max_idx !== 8'd0 || min_idx !== 8'd0) begin
      errors++;
      $display("FAIL single_result: ov=%0b max=%h min=%h cnt=%0d required 1 1234 1234 1",
               out_valid, max_val, min_val, count);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || max_val !== 16'h1234 || min_val !== 16'h1234 ||
          count !== 8'd1 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_hold: unstable cycles=%0d required 0", bad);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || count !== 8'd0 || in_ready !== 1'b1 || max_val !== 16'h1234) begin
      errors++;
      $display("FAIL single_consume: ov=%0b cnt=%0d rdy=%0b max=%h required 0 0 1 1234",
               out_valid, count, in_ready, max_val);
    end
  endtask

  task automatic test_illegal();
    send(16'h0010, 1'b0);
    send(16'h0020, 1'b1);
    force_bad = 1'b1;
    @(negedge clk);
    force_bad = 1'b0;
    wait_out();
    checks++;
    if (max_val !== 16'h0010 || max_idx !== 8'd0 || min_val !== 16'h0010 || cmp_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_cmp: max=%h@%0d min=%h err=%0b required 0010@0 0010 1",
               max_val, max_idx, min_val, cmp_err);
    end
    consume();
    send(16'h0005, 1'b0);
    send(16'h0007, 1'b1);
    wait_out();
    checks++;
    if (cmp_err !== 1'b1 || max_val !== 16'h0007 || max_idx !== 8'd1 || min_val !== 16'h0005) begin
      errors++;
      $display("FAIL err_sticky: err=%0b max=%h@%0d min=%h required 1 0007@1 0005",
               cmp_err, max_val, max_idx, min_val);
    end
    consume();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (cmp_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%0b required 0", cmp_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vd [4];
    logic        vl [4];
    logic [15:0] cap_max [2];
    logic [15:0] cap_min [2];
    logic [7:0]  cap_maxi [2];
    logic [7:0]  cap_mini [2];
    logic [7:0]  cap_cnt [2];
    int          i;
    int          nf;
    vd[0] = 16'h0100; vl[0] = 1'b0;
    vd[1] = 16'h0050; vl[1] = 1'b1;
    vd[2] = 16'h0300; vl[2] = 1'b0;
    vd[3] = 16'h0400; vl[3] = 1'b1;
    i  = 0;
    nf = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && nf < 2) begin
        cap_max[nf]  = max_val;
        cap_min[nf]  = min_val;
        cap_maxi[nf] = max_idx;
        cap_mini[nf] = min_idx;
        cap_cnt[nf]  = count;
        nf++;
      end
      if (i < 4) begin
        in_valid = 1'b1;
        in_data  = vd[i];
        in_last  = vl[i];
        if (in_ready) i++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (nf != 2) begin
      errors++;
      $display("FAIL b2b_frames: frames=%0d required 2", nf);
    end else begin
      checks++;
      if (cap_max[0] !== 16'h0100 || cap_maxi[0] !== 8'd0 || cap_min[0] !== 16'h0050 ||
          cap_mini[0] !== 8'd1 || cap_cnt[0] !== 8'd2) begin
        errors++;
        $display("FAIL b2b_frame0: max=%h@%0d min=%h@%0d cnt=%0d required 0100@0 0050@1 2",
                 cap_max[0], cap_maxi[0], cap_min[0], cap_mini[0], cap_cnt[0]);
      end
      checks++;
      if (cap_max[1] !== 16'h0400 || cap_maxi[1] !== 8'd1 || cap_min[1] !== 16'h0300 ||
          cap_mini[1] !== 8'd0 || cap_cnt[1] !== 8'd2) begin
        errors++;
        $display("FAIL b2b_frame1: max=%h@%0d min=%h@%0d cnt=%0d required 0400@1 0300@0 2",
                 cap_max[1], cap_maxi[1], cap_min[1], cap_mini[1], cap_cnt[1]);
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k <= 256; k++) begin
      if (k == 256)      send(16'hFFFF, 1'b1);
      else if (k == 200) send(16'h0001, 1'b0);
      else               send(16'h0100, 1'b0);
    end
    wait_out();
    checks++;
    if (count !== 8'd255 || max_val !== 16'hFFFF || max_idx !== 8'd255 ||
        min_val !== 16'h0001 || min_idx !== 8'd200) begin
      errors++;
      $display("FAIL saturation: cnt=%0d max=%h@%0d min=%h@%0d required 255 ffff@255 0001@200",
               count, max_val, max_idx, min_val, min_idx);
    end
    consume();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    force_bad = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    test_reset();
    test_frame_basic();
    test_ties();
    test_single();
    test_illegal();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
